// File: rtl/kbd_pkg.sv
// Shared constants and types for the matrix keyboard controller.
package kbd_pkg;

    localparam int unsigned KEY_NUM       = 16;
    localparam int unsigned KEY_IDX_W     = 4;
    localparam int unsigned EVT_W         = 5;
    localparam int unsigned EVT_PRESS_BIT = 4;

    // Controller FSM: wait for a debounced change, walk the 16 keys, commit the new map.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        COMMIT = 2'd2
    } kbd_state_e;

    // Event word: {press, code[3:0]}.
    typedef logic [EVT_W-1:0] kbd_evt_t;

    function automatic kbd_evt_t pack_evt(input logic [KEY_IDX_W-1:0] code, input logic press);
        return {press, code};
    endfunction

endpackage

// File: rtl/matrix_keyboard_ctrl_if.sv
// Event handshake between the keyboard controller (master) and its consumer (slave).
interface matrix_keyboard_ctrl_if;
    import kbd_pkg::*;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [KEY_IDX_W-1:0] evt_code;
    logic                 evt_press;
    logic                 evt_overflow;
    logic                 ovf_clr;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        output evt_overflow,
        input  evt_ready,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        input  evt_overflow,
        output evt_ready,
        output ovf_clr
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// Show-ahead event FIFO; a push while full is dropped unless a pop frees a slot that cycle.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_100M,
    input  logic     rst_n,
    input  logic     i_push,
    input  kbd_evt_t i_push_data,
    input  logic     i_pop,
    output logic     o_empty,
    output kbd_evt_t o_head,
    output logic     o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    kbd_evt_t    r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign o_drop    = i_push && w_full && !w_pop_ok;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update on accepted push/pop.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is cleared so the head reads as zero out of reset.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/matrix_keyboard_ctrl.sv
// Matrix keyboard controller: frame timing, per-frame debounce, press/release event generation.
module matrix_keyboard_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES    = 2_000_000,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                   clk_100M,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [KEY_NUM-1:0]     i_key_raw,
    output logic                   o_scan_en,
    output logic [KEY_NUM-1:0]     o_key_state,
    matrix_keyboard_ctrl_if.master evt_if
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [3:0]       STAB_MAX = 4'(DEBOUNCE_FRAMES - 1);

    logic                 r_scan_en;
    logic [CNT_W-1:0]     r_frame_cnt;
    logic [KEY_NUM-1:0]   r_last_snap;
    logic [3:0]           r_stable_cnt;
    logic [KEY_NUM-1:0]   r_key_state;
    logic [KEY_NUM-1:0]   r_chg;
    logic [KEY_NUM-1:0]   r_new_state;
    logic [KEY_IDX_W-1:0] r_idx;
    logic                 r_ovf;
    kbd_state_e           r_state;

    kbd_state_e           w_state_d;
    logic                 w_frame_tick;
    logic                 w_sample;
    logic [KEY_NUM-1:0]   w_snap;
    logic [KEY_NUM-1:0]   w_last_nxt;
    logic [3:0]           w_stable_nxt;
    logic                 w_qualify;
    logic                 w_push;
    kbd_evt_t             w_push_data;
    logic                 w_commit;
    logic                 w_empty;
    kbd_evt_t             w_head;
    logic                 w_drop;

    assign w_frame_tick = i_en && (r_frame_cnt == CNT_MAX);
    // Ticks that land while a walk is in progress are simply skipped.
    assign w_sample     = w_frame_tick && (r_state == IDLE);

    // Scanner enable follows the software enable by one cycle.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) r_scan_en <= 1'b0;
        else        r_scan_en <= i_en;
    end

    // Frame counter: free-runs while enabled, holds while disabled.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (i_en) begin
            if (r_frame_cnt == CNT_MAX) r_frame_cnt <= '0;
            else                        r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Debounce next values and the qualify decision, based on post-update counters.
    always_comb begin
        w_snap       = ~i_key_raw;
        w_last_nxt   = r_last_snap;
        w_stable_nxt = r_stable_cnt;
        if (w_sample) begin
            if (w_snap == r_last_snap) begin
                if (r_stable_cnt != STAB_MAX) w_stable_nxt = r_stable_cnt + 1'b1;
            end else begin
                w_last_nxt   = w_snap;
                w_stable_nxt = '0;
            end
        end
        w_qualify = w_sample && (w_stable_nxt == STAB_MAX) && (w_last_nxt != r_key_state);
    end

    // Debounce registers.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_last_snap  <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_last_snap  <= w_last_nxt;
            r_stable_cnt <= w_stable_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_d;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (w_qualify) w_state_d = WALK;
            WALK:    if (r_idx == KEY_IDX_W'(KEY_NUM - 1)) w_state_d = COMMIT;
            COMMIT:  w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // FSM outputs: one push per changed key during the walk, map update in COMMIT.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = pack_evt(r_idx, r_new_state[r_idx]);
        w_commit    = 1'b0;
        unique case (r_state)
            WALK:    w_push   = r_chg[r_idx];
            COMMIT:  w_commit = 1'b1;
            default: ;
        endcase
    end

    // Walk datapath: capture the change set on qualify, step the key index during WALK.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_chg       <= '0;
            r_new_state <= '0;
            r_idx       <= '0;
        end else if (w_qualify) begin
            r_chg       <= w_last_nxt ^ r_key_state;
            r_new_state <= w_last_nxt;
            r_idx       <= '0;
        end else if (r_state == WALK) begin
            r_idx       <= r_idx + 1'b1;
        end
    end

    // Debounced key map.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n)        r_key_state <= '0;
        else if (w_commit) r_key_state <= r_new_state;
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n)              r_ovf <= 1'b0;
        else if (w_drop)         r_ovf <= 1'b1;
        else if (evt_if.ovf_clr) r_ovf <= 1'b0;
    end

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (evt_if.evt_ready),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_drop      (w_drop)
    );

    assign o_scan_en           = r_scan_en;
    assign o_key_state         = r_key_state;
    assign evt_if.evt_valid    = !w_empty;
    assign evt_if.evt_code     = w_head[KEY_IDX_W-1:0];
    assign evt_if.evt_press    = w_head[EVT_PRESS_BIT];
    assign evt_if.evt_overflow = r_ovf;

endmodule
